amba_axi4_lite_slave_gen: RTL and testbench
===========================================

// Module: amba_axi4_lite_slave_gen
// PURPOSE
//  Parametrised AXI4-Lite slave front-end for a NUM_REGS-deep external register bank.
//  Independent write and read channels. AW and W are accepted in either order or together.
//  Responses are registered and held until the master accepts them. Busy or out-of-range
//  accesses get SLVERR and perform no bank access. Sits between the system AXI4-Lite
//  interconnect and the IP's register bank and control logic.
// PARAMETERS
//  ADDR_W    32  AXI address width
//  DATA_W    32  AXI data width; 32 or 64. STRB_W=DATA_W/8, OFS_W=$clog2(STRB_W)
//  NUM_REGS  4   number of bank words (>=1). IDX_W=max(1,$clog2(NUM_REGS))
//  BASE_ADDR 0   byte address of bank word 0; must be STRB_W-aligned
// PORTS
//  ACLK       in   1       clock; all logic on rising edge
//  ARSTn      in   1       synchronous active-low reset
//  AWVALID    in   1       write address valid
//  AWREADY    out  1       write address ready
//  AWADDR     in   ADDR_W  write byte address
//  AWPROT     in   3       ignored
//  WVALID     in   1       write data valid
//  WREADY     out  1       write data ready
//  WDATA      in   DATA_W  write data
//  WSTRB      in   STRB_W  byte lane enables
//  BVALID     out  1       write response valid
//  BREADY     in   1       write response ready
//  BRESP      out  2       2'b00 OKAY, 2'b10 SLVERR
//  ARVALID    in   1       read address valid
//  ARREADY    out  1       read address ready
//  ARADDR     in   ADDR_W  read byte address
//  ARPROT     in   3       ignored
//  RVALID     out  1       read data valid
//  RREADY     in   1       read data ready
//  RDATA      out  DATA_W  read data
//  RRESP      out  2       2'b00 OKAY, 2'b10 SLVERR
//  i_is_busy  in   1       IP busy; sampled at the access decision edge
//  o_wr_en    out  1       one-cycle bank write strobe
//  o_wr_idx   out  IDX_W   bank word index for write
//  o_wr_data  out  DATA_W  bank write data
//  o_wr_strb  out  STRB_W  bank byte enables
//  o_rd_en    out  1       one-cycle bank read strobe
//  o_rd_idx   out  IDX_W   bank word index for read
//  i_rd_data  in   DATA_W  bank read data; valid the cycle after o_rd_en
// BEHAVIOUR
//  Reset (ARSTn=0 at edge)
//   - All outputs registered to 0: READYs, VALIDs, RESPs, RDATA, o_wr_*, o_rd_*.
//   - Pending AW/W/AR captures and pending responses are discarded.
//   - Any transaction in progress when reset asserts is aborted. No o_wr_en pulse follows.
//  Decode
//   - hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR + NUM_REGS*STRB_W). Compare at ADDR_W+1 bits so the upper bound does not wrap.
//   - idx = (addr - BASE_ADDR) >> OFS_W. Addr bits [OFS_W-1:0] are ignored.
//   - ok = hit && !i_is_busy.
//  Write FSM: WR_IDLE -> WR_COLLECT -> WR_RESP
//   - WR_IDLE: entered on the first cycle after reset. READYs are low. Next state is WR_COLLECT.
//   - WR_COLLECT: AWREADY=1 while AW is not yet held; WREADY=1 while W is not yet held.
//     A handshake captures the beat and drops that READY next cycle. AW and W may arrive in the same cycle.
//   - Decision edge: the first edge at which both AW and W are held. At that edge, register:
//       BVALID<=1; BRESP<=ok?00:10; o_wr_en<=ok; o_wr_idx/data/strb<=captured values.
//     The FSM moves to WR_RESP.
//     If both beats handshake at edge N, the decision edge is N+1: o_wr_en and BVALID rise after edge N+1.
//   - WR_RESP: o_wr_en is high for exactly one cycle. BVALID/BRESP are held stable until BVALID&&BREADY.
//     On that edge BVALID<=0, both holds are cleared, and the FSM returns to WR_COLLECT. AWREADY/WREADY rise in the next cycle.
//   - WSTRB=0 with ok=1 is a legal OKAY write: o_wr_en=1, o_wr_strb=0.
//  Read FSM: RD_IDLE -> RD_ADDR -> RD_FETCH -> RD_RESP
//   - RD_IDLE: ARREADY=0 for one cycle after reset.
//   - RD_ADDR: ARREADY=1. A handshake at edge N captures ARADDR, registers o_rd_en<=ok and o_rd_idx, and enters RD_FETCH.
//   - RD_FETCH (one cycle): at edge N+1, RDATA<=ok?i_rd_data:0, RRESP<=ok?00:10, RVALID<=1, enter RD_RESP. o_rd_en drops.
//   - RD_RESP: RDATA/RRESP are held until RVALID&&RREADY; then RVALID<=0 and the FSM returns to RD_ADDR.
//  Concurrency
//   - The read and write channels are fully independent. o_wr_en and o_rd_en may both be high in the same cycle.
//   - Same-index ordering is not guaranteed and is the bank's concern.
//   - The busy decision is independent per channel.
// TESTING
//  1. AW+W together, addr 0x8, WDATA 0xDEADBEEF, WSTRB 0xF, BREADY=1 -> one o_wr_en pulse, idx 2, BRESP 00.
//  2. W three cycles before AW (addr 0x4) -> WREADY low after W captured; single write at idx 1; BRESP 00.
//  3. Write then read with BREADY/RREADY held low 5 cycles -> BVALID/RVALID and RESP/RDATA stable until ready; no second o_wr_en.
//  4. Addresses 0x10 and BASE-4, NUM_REGS=4 -> SLVERR, o_wr_en/o_rd_en stay 0, RDATA 0.
//  5. i_is_busy=1 at decision edge -> SLVERR, no bank access; busy=0 -> OKAY, read returns i_rd_data (e.g. 0x12345678).
//  6. ARSTn low while BVALID high and a read is in RD_FETCH -> all outputs 0 next cycle; clean transactions after release.

Source files
------------

// File: rtl/amba_axi4_lite_slave_gen.sv
// AXI4-Lite slave front-end for an external NUM_REGS-word register bank.
// Write and read channels run as independent FSMs. Responses are registered.
module amba_axi4_lite_slave_gen #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int               STRB_W    = DATA_W / 8,
  localparam int               OFS_W     = $clog2(STRB_W),
  localparam int               IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              ACLK,
  input  logic              ARSTn,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  input  logic              i_is_busy,
  output logic              o_wr_en,
  output logic [IDX_W-1:0]  o_wr_idx,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [STRB_W-1:0] o_wr_strb,
  output logic              o_rd_en,
  output logic [IDX_W-1:0]  o_rd_idx,
  input  logic [DATA_W-1:0] i_rd_data
);

  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;
  localparam logic [ADDR_W:0] BASE_EXT    = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] LIMIT_EXT   = BASE_EXT + (ADDR_W+1)'(NUM_REGS * STRB_W);

  typedef enum logic [1:0] {WR_IDLE, WR_COLLECT, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_FETCH, RD_RESP} rd_state_t;

  wr_state_t          wr_state;
  rd_state_t          rd_state;
  logic               aw_held;
  logic               w_held;
  logic [ADDR_W-1:0]  awaddr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;
  logic               rd_ok_q;

  // Decode is done one bit wider than the address so the upper bound cannot wrap.
  logic [ADDR_W:0]    wr_ext;
  logic [ADDR_W:0]    rd_ext;
  logic [ADDR_W:0]    wr_ofs;
  logic [ADDR_W:0]    rd_ofs;
  logic               wr_ok;
  logic               rd_ok;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               unused_sink;

  assign wr_ext      = {1'b0, awaddr_q};
  assign rd_ext      = {1'b0, ARADDR};
  assign wr_ofs      = wr_ext - BASE_EXT;
  assign rd_ofs      = rd_ext - BASE_EXT;
  assign wr_idx      = wr_ofs[OFS_W +: IDX_W];
  assign rd_idx      = rd_ofs[OFS_W +: IDX_W];
  assign wr_ok       = (wr_ext >= BASE_EXT) && (wr_ext < LIMIT_EXT) && !i_is_busy;
  assign rd_ok       = (rd_ext >= BASE_EXT) && (rd_ext < LIMIT_EXT) && !i_is_busy;
  assign unused_sink = ^{AWPROT, ARPROT, wr_ofs, rd_ofs};

  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      wr_state  <= WR_IDLE;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      o_wr_en   <= 1'b0;
      o_wr_idx  <= '0;
      o_wr_data <= '0;
      o_wr_strb <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (wr_state)
        WR_IDLE: begin
          AWREADY  <= 1'b1;
          WREADY   <= 1'b1;
          wr_state <= WR_COLLECT;
        end
        WR_COLLECT: begin
          if (AWVALID && AWREADY) begin
            aw_held  <= 1'b1;
            awaddr_q <= AWADDR;
            AWREADY  <= 1'b0;
          end
          if (WVALID && WREADY) begin
            w_held  <= 1'b1;
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
            WREADY  <= 1'b0;
          end
          // Decision edge: both beats were already held before this edge.
          if (aw_held && w_held) begin
            BVALID    <= 1'b1;
            BRESP     <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            o_wr_en   <= wr_ok;
            o_wr_idx  <= wr_idx;
            o_wr_data <= wdata_q;
            o_wr_strb <= wstrb_q;
            wr_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (BVALID && BREADY) begin
            BVALID   <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
            wr_state <= WR_COLLECT;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      rd_state <= RD_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RRESP    <= RESP_OKAY;
      rd_ok_q  <= 1'b0;
      o_rd_en  <= 1'b0;
      o_rd_idx <= '0;
    end else begin
      o_rd_en <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          ARREADY  <= 1'b1;
          rd_state <= RD_ADDR;
        end
        RD_ADDR: begin
          if (ARVALID && ARREADY) begin
            ARREADY  <= 1'b0;
            o_rd_en  <= rd_ok;
            o_rd_idx <= rd_idx;
            rd_ok_q  <= rd_ok;
            rd_state <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          RDATA    <= rd_ok_q ? i_rd_data : '0;
          RRESP    <= rd_ok_q ? RESP_OKAY : RESP_SLVERR;
          RVALID   <= 1'b1;
          rd_state <= RD_RESP;
        end
        RD_RESP: begin
          if (RVALID && RREADY) begin
            RVALID   <= 1'b0;
            ARREADY  <= 1'b1;
            rd_state <= RD_ADDR;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amba_axi4_lite_slave_gen.sv
// Directed bench for amba_axi4_lite_slave_gen (default parameters: 32-bit, 4 words, base 0).
// A small byte-enabled bank sits on the o_wr_*/o_rd_* side; expectations are hand-computed.
module tb_amba_axi4_lite_slave_gen;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        ACLK;
  logic        ARSTn;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [2:0]  AWPROT, ARPROT;
  logic [1:0]  BRESP, RRESP;
  logic        i_is_busy, o_wr_en, o_rd_en;
  logic [1:0]  o_wr_idx, o_rd_idx;
  logic [31:0] o_wr_data, i_rd_data;
  logic [3:0]  o_wr_strb;

  int checks = 0;
  int passed = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  logic [1:0]  last_wr_idx, last_rd_idx;
  logic [31:0] last_wr_data;
  logic [3:0]  last_wr_strb;
  logic        wready_late;
  logic [31:0] bank [4];

  amba_axi4_lite_slave_gen dut (
    .ACLK(ACLK), .ARSTn(ARSTn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .i_is_busy(i_is_busy),
    .o_wr_en(o_wr_en), .o_wr_idx(o_wr_idx), .o_wr_data(o_wr_data), .o_wr_strb(o_wr_strb),
    .o_rd_en(o_rd_en), .o_rd_idx(o_rd_idx), .i_rd_data(i_rd_data)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Bank model: combinational read, byte-enabled write, strobes counted mid-cycle.
  assign i_rd_data = bank[o_rd_idx];

  always @(negedge ACLK) begin
    if (o_wr_en) begin
      wr_pulses++;
      last_wr_idx  = o_wr_idx;
      last_wr_data = o_wr_data;
      last_wr_strb = o_wr_strb;
      for (int b = 0; b < 4; b++)
        if (o_wr_strb[b]) bank[o_wr_idx][8*b +: 8] = o_wr_data[8*b +: 8];
    end
    if (o_rd_en) begin
      rd_pulses++;
      last_rd_idx = o_rd_idx;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got === expv) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
  endtask

  // Issues one write; W leads AW by w_lead cycles, BREADY withheld for b_hold cycles.
  task automatic writeTxn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_lead, input int b_hold, input logic [1:0] exp_resp);
    int cyc;
    logic aw_pend, w_pend, aw_hs, w_hs;
    aw_pend = 1'b1; w_pend = 1'b1; cyc = 0; wready_late = 1'b0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    BREADY = (b_hold == 0);
    while ((aw_pend || w_pend) && cyc < 40) begin
      if (w_pend) WVALID = 1'b1;
      if (aw_pend && cyc >= w_lead) AWVALID = 1'b1;
      if (!w_pend && aw_pend && WREADY) wready_late = 1'b1;
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(negedge ACLK);
      cyc++;
      if (aw_hs) begin aw_pend = 1'b0; AWVALID = 1'b0; end
      if (w_hs)  begin w_pend  = 1'b0; WVALID  = 1'b0; end
    end
    if (aw_pend || w_pend) checkOutput("wr_handshake_timeout", 1, 0);
    cyc = 0;
    while (!BVALID && cyc < 40) begin @(negedge ACLK); cyc++; end
    checkOutput("bvalid", BVALID, 1);
    checkOutput("bresp", BRESP, exp_resp);
    for (int i = 0; i < b_hold; i++) begin
      @(negedge ACLK);
      checkOutput("bvalid_hold", BVALID, 1);
      checkOutput("bresp_hold", BRESP, exp_resp);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    checkOutput("bvalid_clear", BVALID, 0);
    BREADY = 1'b0;
  endtask

  task automatic readTxn(input logic [31:0] addr, input int r_hold,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int cyc;
    ARADDR = addr; ARVALID = 1'b1;
    RREADY = (r_hold == 0);
    cyc = 0;
    while (!ARREADY && cyc < 40) begin @(negedge ACLK); cyc++; end
    if (!ARREADY) checkOutput("ar_handshake_timeout", 1, 0);
    @(negedge ACLK);
    ARVALID = 1'b0;
    cyc = 0;
    while (!RVALID && cyc < 40) begin @(negedge ACLK); cyc++; end
    checkOutput("rvalid", RVALID, 1);
    checkOutput("rresp", RRESP, exp_resp);
    checkOutput("rdata", RDATA, exp_data);
    for (int i = 0; i < r_hold; i++) begin
      @(negedge ACLK);
      checkOutput("rvalid_hold", RVALID, 1);
      checkOutput("rdata_hold", RDATA, exp_data);
      checkOutput("rresp_hold", RRESP, exp_resp);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    checkOutput("rvalid_clear", RVALID, 0);
    RREADY = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP,
                                 o_wr_en, o_wr_idx, o_wr_strb, o_rd_en, o_rd_idx}, 0);
    checkOutput({tag, "_data"}, {RDATA, o_wr_data}, 0);
  endtask

  initial begin
    int p0, r0;
    ARSTn = 1'b0; i_is_busy = 1'b0;
    AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    AWADDR = 0; ARADDR = 0; WDATA = 0; WSTRB = 0; AWPROT = 0; ARPROT = 0;

    // Reset state, then one IDLE cycle before the READYs come up.
    repeat (3) @(negedge ACLK);
    checkAllZero("reset");
    ARSTn = 1'b1;
    @(negedge ACLK);
    checkOutput("readys_after_idle", {AWREADY, WREADY, ARREADY}, 3'b111);

    // AW and W together at 0x8.
    p0 = wr_pulses;
    writeTxn(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, OKAY);
    checkOutput("t1_pulses", wr_pulses - p0, 1);
    checkOutput("t1_idx", last_wr_idx, 2);
    checkOutput("t1_data", last_wr_data, 32'hDEADBEEF);
    checkOutput("t1_strb", last_wr_strb, 4'hF);

    // W three cycles ahead of AW.
    p0 = wr_pulses;
    writeTxn(32'h4, 32'h0BADF00D, 4'hF, 3, 0, OKAY);
    checkOutput("t2_wready_low", wready_late, 0);
    checkOutput("t2_pulses", wr_pulses - p0, 1);
    checkOutput("t2_idx", last_wr_idx, 1);

    // Stalled responses, partial strobe merge, unaligned read address.
    p0 = wr_pulses;
    writeTxn(32'h8, 32'h11223344, 4'h3, 0, 5, OKAY);
    repeat (3) @(negedge ACLK);
    checkOutput("t3_single_pulse", wr_pulses - p0, 1);
    checkOutput("t3_strb", last_wr_strb, 4'h3);
    r0 = rd_pulses;
    readTxn(32'h8, 5, 32'hDEAD3344, OKAY);
    readTxn(32'h7, 0, 32'h0BADF00D, OKAY);
    checkOutput("t3_rd_pulses", rd_pulses - r0, 2);
    checkOutput("t3_rd_idx", last_rd_idx, 1);

    // Out-of-range: one past the end, and BASE-4 (wraps to 0xFFFFFFFC).
    p0 = wr_pulses; r0 = rd_pulses;
    writeTxn(32'h10, 32'h99999999, 4'hF, 0, 0, SLVERR);
    writeTxn(32'hFFFFFFFC, 32'h99999999, 4'hF, 1, 0, SLVERR);
    readTxn(32'h10, 0, 32'h0, SLVERR);
    readTxn(32'hFFFFFFFC, 0, 32'h0, SLVERR);
    checkOutput("t4_no_wr", wr_pulses - p0, 0);
    checkOutput("t4_no_rd", rd_pulses - r0, 0);

    // Zero strobe is still an OKAY write with a strobe pulse.
    p0 = wr_pulses;
    writeTxn(32'h0, 32'hCAFEBABE, 4'h0, 0, 0, OKAY);
    checkOutput("strb0_pulses", wr_pulses - p0, 1);
    checkOutput("strb0_strb", last_wr_strb, 4'h0);
    checkOutput("strb0_idx", last_wr_idx, 0);

    // Busy gating on both channels.
    p0 = wr_pulses; r0 = rd_pulses;
    i_is_busy = 1'b1;
    writeTxn(32'hC, 32'h12345678, 4'hF, 0, 0, SLVERR);
    checkOutput("t5_busy_no_wr", wr_pulses - p0, 0);
    i_is_busy = 1'b0;
    writeTxn(32'hC, 32'h12345678, 4'hF, 0, 0, OKAY);
    checkOutput("t5_wr", wr_pulses - p0, 1);
    checkOutput("t5_idx", last_wr_idx, 3);
    i_is_busy = 1'b1;
    readTxn(32'hC, 0, 32'h0, SLVERR);
    checkOutput("t5_busy_no_rd", rd_pulses - r0, 0);
    i_is_busy = 1'b0;
    readTxn(32'hC, 0, 32'h12345678, OKAY);
    checkOutput("t5_rd", rd_pulses - r0, 1);

    // Reset while BVALID is pending and a read sits in RD_FETCH.
    AWADDR = 32'h0; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    @(negedge ACLK);
    checkOutput("t6_bvalid_pending", BVALID, 1);
    ARADDR = 32'h4; ARVALID = 1;
    @(negedge ACLK);
    checkOutput("t6_rd_fetch", o_rd_en, 1);
    ARVALID = 0; ARSTn = 1'b0;
    @(negedge ACLK);
    checkAllZero("t6_reset");
    p0 = wr_pulses;
    repeat (3) @(negedge ACLK);
    checkOutput("t6_no_pulse", wr_pulses - p0, 0);
    ARSTn = 1'b1;
    @(negedge ACLK);
    writeTxn(32'hC, 32'hA0A0A0A0, 4'hF, 0, 0, OKAY);
    checkOutput("t6_post_wr", wr_pulses - p0, 1);
    readTxn(32'hC, 0, 32'hA0A0A0A0, OKAY);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
